// File: rtl/hub75_bcm_scheduler_pkg.sv
// Shared types and width helpers for the HUB75 BCM scan path
// (scheduler, column shifter and panel driver).
package hub75_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_BLANK,
        S_LATCH
    } state_t;

    // Row-pair address width for a panel of 'rows' addressable rows.
    function automatic int addr_bits(input int rows);
        return (rows / 2 > 1) ? $clog2(rows / 2) : 1;
    endfunction

    // Bit-plane index width.
    function automatic int plane_bits(input int pwm_bits);
        return (pwm_bits > 1) ? $clog2(pwm_bits) : 1;
    endfunction

    // Display timer width: must hold base << (pwm_bits-1).
    function automatic int oe_cnt_bits(input int base, input int pwm_bits);
        return $clog2(base << (pwm_bits - 1)) + 1;
    endfunction

    // Widths for the default 64-row, 8-plane, 4-cycle-base panel.
    localparam int ADDRBITS    = addr_bits(64);
    localparam int PLANEBITS   = plane_bits(8);
    localparam int OE_CNT_BITS = oe_cnt_bits(4, 8);

endpackage

// File: rtl/hub75_bcm_scheduler_if.sv
// Scheduler <-> column shifter command bus, including frame marker and
// the double-buffer select the shifter reads from.
interface hub75_bcm_scheduler_if #(
    parameter int ADDR_W  = 5,
    parameter int PLANE_W = 3
) ();
    logic               shift_start;
    logic [ADDR_W-1:0]  shift_row;
    logic [PLANE_W-1:0] shift_plane;
    logic               shift_done;
    logic               frame_start;
    logic               buffer_select;

    modport master (
        output shift_start,
        output shift_row,
        output shift_plane,
        output frame_start,
        output buffer_select,
        input  shift_done
    );

    modport slave (
        input  shift_start,
        input  shift_row,
        input  shift_plane,
        input  frame_start,
        input  buffer_select,
        output shift_done
    );
endinterface

// File: rtl/hub75_bcm_scheduler_oe_timer.sv
// Loadable down-counter holding the remaining OE-low time of the
// currently displayed bit-plane.
module hub75_oe_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             expire
);
    logic [CNT_W-1:0] cnt;

    // Load a new on-time at latch, otherwise count down to zero and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // busy qualifies OE; expire flags that the counter is zero after this cycle.
    assign busy   = (cnt != '0);
    assign expire = (cnt <= CNT_W'(1));

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 binary-coded-modulation scheduler: steps (row, plane) units,
// overlaps the next shift with the current display, and applies buffer
// swaps only at the start of a frame.
module hub75_bcm_scheduler
    import hub75_pkg::*;
#(
    parameter int  ROWS           = 64,
    parameter int  PWM_BITS       = 8,
    parameter int  BASE_OE_CYCLES = 4,
    parameter int  BLANK_CYCLES   = 2,
    localparam int ADDR_W         = addr_bits(ROWS),
    localparam int PLANE_W        = plane_bits(PWM_BITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  swap_req,
    output logic                  swap_ack,
    hub75_bcm_scheduler_if.master sh,
    output logic [ADDR_W-1:0]     ROWSEL,
    output logic                  LATCH,
    output logic                  OE
);
    localparam int ROWS_2  = ROWS / 2;
    localparam int CNT_W   = oe_cnt_bits(BASE_OE_CYCLES, PWM_BITS);
    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    state_t             state;
    state_t             state_nxt;
    logic               in_shift_d;
    logic [ADDR_W-1:0]  row_q;
    logic [PLANE_W-1:0] plane_q;
    logic [ADDR_W-1:0]  rowsel_q;
    logic [BLANK_W-1:0] blank_cnt;
    logic               buf_q;
    logic               swap_pending;
    logic               shift_first;
    logic               frame_first;
    logic               apply_swap;
    logic               disp_busy;
    logic               disp_expire;
    logic [CNT_W-1:0]   disp_load_val;

    // The on-time loaded at latch belongs to the unit just shifted.
    assign disp_load_val = CNT_W'(BASE_OE_CYCLES) << plane_q;

    hub75_oe_timer #(
        .CNT_W (CNT_W)
    ) u_oe_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == S_LATCH),
        .load_val (disp_load_val),
        .busy     (disp_busy),
        .expire   (disp_expire)
    );

    assign shift_first = (state == S_SHIFT) && !in_shift_d;
    assign frame_first = shift_first && (row_q == '0) && (plane_q == '0);
    assign apply_swap  = frame_first && (swap_pending || swap_req);

    assign sh.shift_start   = shift_first;
    assign sh.shift_row     = row_q;
    assign sh.shift_plane   = plane_q;
    assign sh.frame_start   = frame_first;
    // A swap applied this cycle is already visible on the frame's first shift.
    assign sh.buffer_select = buf_q ^ apply_swap;
    assign swap_ack         = apply_swap;

    assign ROWSEL = rowsel_q;
    assign LATCH  = (state == S_LATCH);
    assign OE     = !(disp_busy && (state != S_BLANK) && (state != S_LATCH));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. WAIT leaves as the timer hits zero, so blanking
    // starts in the first cycle with no display time left.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (enable) state_nxt = S_SHIFT;
            S_SHIFT: if (sh.shift_done && !shift_first) state_nxt = S_WAIT;
            S_WAIT:  if (disp_expire) state_nxt = S_BLANK;
            S_BLANK: if (blank_cnt == BLANK_W'(BLANK_CYCLES - 1)) state_nxt = S_LATCH;
            S_LATCH: state_nxt = enable ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shift-entry edge detect and blanking-length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_shift_d <= 1'b0;
            blank_cnt  <= '0;
        end else begin
            in_shift_d <= (state == S_SHIFT);
            blank_cnt  <= (state == S_BLANK) ? blank_cnt + BLANK_W'(1) : '0;
        end
    end

    // At latch: display the shifted row, then advance plane (inner) and row (outer).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            plane_q  <= '0;
            rowsel_q <= '0;
        end else if (state == S_LATCH) begin
            rowsel_q <= row_q;
            if (plane_q == PLANE_W'(PWM_BITS - 1)) begin
                plane_q <= '0;
                row_q   <= (row_q == ADDR_W'(ROWS_2 - 1)) ? '0 : row_q + ADDR_W'(1);
            end else begin
                plane_q <= plane_q + PLANE_W'(1);
            end
        end
    end

    // Swap requests collect until the next frame start, then toggle once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q        <= 1'b0;
            swap_pending <= 1'b0;
        end else if (apply_swap) begin
            buf_q        <= ~buf_q;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Directed bench for hub75_bcm_scheduler: 4-row, 3-plane panel with a
// behavioural column shifter answering each shift_start after a delay.
module tb_hub75_bcm_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic [0:0] ROWSEL;
    logic       LATCH;
    logic       OE;

    hub75_bcm_scheduler_if #(.ADDR_W(1), .PLANE_W(2)) sh ();

    hub75_bcm_scheduler #(
        .ROWS           (4),
        .PWM_BITS       (3),
        .BASE_OE_CYCLES (2),
        .BLANK_CYCLES   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .swap_req (swap_req),
        .swap_ack (swap_ack),
        .sh       (sh),
        .ROWSEL   (ROWSEL),
        .LATCH    (LATCH),
        .OE       (OE)
    );

    always #5 clk = ~clk;

    // Shifter model: done pulse 5 cycles after start, 20 for plane-1 shifts when slow_p1.
    logic slow_p1 = 1'b0;
    int   sh_cnt  = 0;
    initial begin
        sh.shift_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sh.shift_done = 1'b0;
            if (!rst_n) begin
                sh_cnt = 0;
            end else begin
                if (sh_cnt != 0) begin
                    sh_cnt--;
                    if (sh_cnt == 0) sh.shift_done = 1'b1;
                end
                if (sh.shift_start)
                    sh_cnt = (slow_p1 && sh.shift_plane == 2'd1) ? 20 : 5;
            end
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observation logs filled once per cycle.
    int   cyc = 0;
    int   ss_cyc[$], ss_row[$], ss_plane[$], ss_frame[$];
    int   oe_runs[$], hi_latch[$], rowsel_log[$];
    int   latch_n = 0, ack_n = 0, bs_tog = 0;
    int   lo_run = 0, hi_run = 0;
    logic latch_prev = 1'b0, bs_prev = 1'b0, done_seen = 1'b0;

    task automatic clear_logs();
        ss_cyc.delete(); ss_row.delete(); ss_plane.delete(); ss_frame.delete();
        oe_runs.delete(); hi_latch.delete(); rowsel_log.delete();
        latch_n = 0; ack_n = 0; bs_tog = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (sh.shift_start) begin
            ss_cyc.push_back(cyc);
            ss_row.push_back(int'(sh.shift_row));
            ss_plane.push_back(int'(sh.shift_plane));
            ss_frame.push_back(int'(sh.frame_start));
            done_seen = 1'b0;
        end
        if (sh.shift_done) done_seen = 1'b1;
        if (OE == 1'b0) begin
            lo_run++;
            hi_run = 0;
        end else begin
            if (lo_run > 0) oe_runs.push_back(lo_run);
            lo_run = 0;
            hi_run++;
        end
        if (latch_prev) rowsel_log.push_back(int'(ROWSEL));
        latch_prev = LATCH;
        if (LATCH) begin
            latch_n++;
            hi_latch.push_back(hi_run);
            chk("latch_after_done", done_seen, 1);
        end
        if (swap_ack) ack_n++;
        if (sh.buffer_select !== bs_prev) bs_tog++;
        bs_prev = sh.buffer_select;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!sh.frame_start && n < 200);
        chk(tag, sh.frame_start, 1);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    int exp_ss[8]    = '{1, 11, 21, 31, 42, 52, 62, 73};
    int exp_row[8]   = '{0, 0, 0, 1, 1, 1, 0, 0};
    int exp_plane[8] = '{0, 1, 2, 0, 1, 2, 0, 1};
    int exp_frame[8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    int exp_runs[6]  = '{2, 4, 8, 2, 4, 8};
    int exp_rsel[7]  = '{0, 0, 0, 1, 1, 1, 0};

    initial begin
        int n;

        // Reset values while rst_n is held low
        repeat (2) step();
        chk("rst_oe", OE, 1);
        chk("rst_latch", LATCH, 0);
        chk("rst_rowsel", ROWSEL, 0);
        chk("rst_bufsel", sh.buffer_select, 0);
        chk("rst_shift_start", sh.shift_start, 0);
        chk("rst_frame_start", sh.frame_start, 0);
        chk("rst_swap_ack", swap_ack, 0);
        chk("rst_shift_row", sh.shift_row, 0);
        chk("rst_shift_plane", sh.shift_plane, 0);

        // Out of reset, disabled: panel stays dark for 50 cycles
        rst_n = 1'b1;
        clear_logs();
        repeat (50) begin
            step();
            chk("idle_oe", OE, 1);
            chk("idle_latch", LATCH, 0);
        end
        chk("idle_no_shift", ss_cyc.size(), 0);
        chk("idle_rowsel", ROWSEL, 0);
        chk("idle_bufsel", sh.buffer_select, 0);

        // First frame plus wrap
        enable = 1'b1;
        cyc = 0;
        clear_logs();
        repeat (73) step();
        chk("scan_ss_count", ss_cyc.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("scan_ss_cyc%0d", i), qget(ss_cyc, i), exp_ss[i]);
            chk($sformatf("scan_row%0d", i), qget(ss_row, i), exp_row[i]);
            chk($sformatf("scan_plane%0d", i), qget(ss_plane, i), exp_plane[i]);
            chk($sformatf("scan_frame%0d", i), qget(ss_frame, i), exp_frame[i]);
        end
        chk("scan_run_count", oe_runs.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("oe_run%0d", i), qget(oe_runs, i), exp_runs[i]);
        chk("scan_latch_count", latch_n, 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("rowsel%0d", i), qget(rowsel_log, i), exp_rsel[i]);
        for (int i = 1; i < 7; i++)
            chk($sformatf("blank_before_latch%0d", i), qget(hi_latch, i) >= 3, 1);
        chk("blank_exact_p2_a", qget(hi_latch, 3), 3);
        chk("blank_exact_p2_b", qget(hi_latch, 6), 3);

        // Two swap requests in one frame: a single toggle at the next frame start
        wait_frame("swap_frame0");
        clear_logs();
        repeat (10) step();
        swap_req = 1'b1; step(); swap_req = 1'b0;
        repeat (10) step();
        swap_req = 1'b1; step(); swap_req = 1'b0;
        chk("swap_not_early", sh.buffer_select, 0);
        wait_frame("swap_frame1");
        chk("swap_ack_at_frame", swap_ack, 1);
        chk("swap_bufsel_at_frame", sh.buffer_select, 1);
        repeat (70) step();
        chk("swap_ack_once", ack_n, 1);
        chk("swap_toggle_once", bs_tog, 1);
        chk("swap_bufsel_hold", sh.buffer_select, 1);

        // Request arriving in the apply cycle is consumed by that apply
        wait_frame("apply_frame");
        chk("apply_no_pending", swap_ack, 0);
        swap_req = 1'b1;
        #1;
        chk("apply_ack", swap_ack, 1);
        chk("apply_bufsel", sh.buffer_select, 0);
        step();
        swap_req = 1'b0;
        clear_logs();
        repeat (70) step();
        chk("apply_no_second_ack", ack_n, 0);
        chk("apply_no_second_toggle", bs_tog, 0);
        chk("apply_bufsel_hold", sh.buffer_select, 0);

        // Slow shift overlapping a plane-0 display
        wait_frame("slow_frame");
        slow_p1 = 1'b1;
        clear_logs();
        repeat (45) step();
        slow_p1 = 1'b0;
        chk("slow_ss_count", ss_cyc.size(), 2);
        chk("slow_spacing", qget(ss_cyc, 1) - qget(ss_cyc, 0), 25);
        chk("slow_run_p2", qget(oe_runs, 0), 8);
        chk("slow_run_p0", qget(oe_runs, 1), 2);
        chk("slow_run_p1", qget(oe_runs, 2), 4);
        chk("slow_dark_until_latch", qget(hi_latch, 1), 23);

        // Async reset while a row-1 plane is on
        swap_req = 1'b1; step(); swap_req = 1'b0;
        wait_frame("prereset_frame");
        chk("prereset_bufsel", sh.buffer_select, 1);
        n = 0;
        while (!(OE == 1'b0 && ROWSEL == 1'b1) && n < 200) begin
            step();
            n++;
        end
        chk("prereset_display", (OE == 1'b0) && (ROWSEL == 1'b1), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_oe", OE, 1);
        chk("arst_latch", LATCH, 0);
        chk("arst_rowsel", ROWSEL, 0);
        chk("arst_bufsel", sh.buffer_select, 0);
        chk("arst_shift_start", sh.shift_start, 0);
        chk("arst_frame_start", sh.frame_start, 0);
        chk("arst_swap_ack", swap_ack, 0);
        chk("arst_shift_row", sh.shift_row, 0);
        chk("arst_shift_plane", sh.shift_plane, 0);
        repeat (3) step();
        rst_n = 1'b1;

        // Enable dropped during the (0,1) shift: unit still latches and displays
        clear_logs();
        n = 0;
        while (ss_cyc.size() < 2 && n < 60) begin
            step();
            n++;
        end
        chk("drop_second_unit", ss_cyc.size(), 2);
        chk("drop_unit_plane", qget(ss_plane, 1), 1);
        repeat (2) step();
        enable = 1'b0;
        clear_logs();
        repeat (40) step();
        chk("drop_no_shift", ss_cyc.size(), 0);
        chk("drop_latch_count", latch_n, 1);
        chk("drop_run_count", oe_runs.size(), 1);
        chk("drop_run_p1", qget(oe_runs, 0), 4);
        chk("drop_rowsel", qget(rowsel_log, 0), 0);
        chk("drop_idle_oe", OE, 1);

        // Re-enable resumes with the next unit, not a new frame
        enable = 1'b1;
        clear_logs();
        n = 0;
        while (ss_cyc.size() < 1 && n < 20) begin
            step();
            n++;
        end
        chk("resume_shift", ss_cyc.size(), 1);
        chk("resume_row", qget(ss_row, 0), 0);
        chk("resume_plane", qget(ss_plane, 0), 2);
        chk("resume_no_frame", qget(ss_frame, 0), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
